ddc_mixer_dec: RTL
==================

DDC_MIXER_DEC -- requirements
Module: ddc_mixer_dec

Interface
REQ-001 SHALL have parameter DIN_W, default 14, meaning ADC sample width.
REQ-002 SHALL have parameter NCO_W, default 14, meaning NCO sin/cos width.
REQ-003 SHALL have parameter DOUT_W, default 16, meaning I/Q output width.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clken  input  1  global clock enable shared with the NCO.
REQ-007 SHALL have port adc_i  input  DIN_W  signed two's-complement ADC sample.
REQ-008 SHALL have port adc_valid  input  1  adc_i valid.
REQ-009 SHALL have port nco_sin, nco_cos  input  NCO_W each  signed NCO fsin_o/fcos_o, time-aligned to adc_i by upstream.
REQ-010 SHALL have port nco_valid  input  1  NCO out_valid.
REQ-011 SHALL have port dec_ratio  input  8  decimation ratio, 1..255; 0 treated as 1.
REQ-012 SHALL have port dec_shift  input  4  output arithmetic right shift, 0..15.
REQ-013 SHALL have ports i_out, q_out  output  DOUT_W each  signed decimated baseband I/Q.
REQ-014 SHALL have port out_valid  output  1  one-cycle strobe marking new i_out/q_out.
REQ-015 SHALL have port ovf  output  1  sticky saturation flag.
REQ-016 SHALL have port ovf_clr  input  1  clears ovf.

Function
REQ-017 SHALL accept a sample on a rising edge only when clken=1, adc_valid=1 and nco_valid=1; other cycles are bubbles and do not advance the frame count.
REQ-018 Stage 1, on the accepting edge E: SHALL register p_i = adc_i*nco_cos and p_q = -(adc_i*nco_sin), full 28-bit signed.
REQ-019 Stage 2, at E+1: SHALL register m = (p + 4096) >>> 13 (round half up), 15-bit signed, no overflow possible.
REQ-020 Stage 3, at E+2: SHALL add m into 24-bit signed accumulators acc_i/acc_q and increment the frame count.
REQ-021 When the frame count reaches ratio_q, the stage-3 edge SHALL load i_out/q_out with sat((acc+m) >>> dec_shift), clear the accumulators to 0, clear the count, and assert out_valid.
REQ-022 sat() SHALL clamp to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; any clamp on I or Q SHALL set ovf.
REQ-023 Output latency SHALL be exactly 2 edges after the edge accepting the frame's last sample.
REQ-024 out_valid SHALL be high for exactly one clk cycle per frame; i_out/q_out SHALL hold between dumps.
REQ-025 ratio_q SHALL load from dec_ratio (0 mapped to 1) during reset and on each dump edge; a dec_ratio change mid-frame SHALL take effect from the next frame.
REQ-026 While clken=0, all pipeline, accumulator, count and output data registers SHALL hold; out_valid SHALL be driven 0.
REQ-027 ovf SHALL clear on ovf_clr=1; a set and a clear on the same edge SHALL leave ovf=1.
REQ-028 Bubbles between samples SHALL NOT alter the arithmetic result, only its timing.

Reset
REQ-029 While reset_n=0 at an edge: i_out, q_out, out_valid, ovf, all pipeline valids, accumulators and the count SHALL be 0; ratio_q SHALL be loaded per REQ-025.
REQ-030 A reset mid-frame SHALL discard the partial frame; the first dump after reset SHALL require ratio_q fresh samples.

Verification
REQ-031 dec_ratio=1, dec_shift=0, adc_i=4096, cos=8191, sin=0 -> i_out=4096, q_out=0, out_valid at E+2.
REQ-032 dec_ratio=4, dec_shift=2, 4x (adc_i=-8192, cos=-8192, sin=8191) -> single out_valid, i_out=8192, q_out=8191.
REQ-033 dec_ratio=8, dec_shift=0, 8x (adc_i=-8192, cos=-8192) -> i_out=32767, ovf=1 and staying 1; ovf_clr pulse -> ovf=0.
REQ-034 dec_ratio=2 with adc_valid toggling and clken=0 for 3 cycles mid-frame -> same i_out/q_out as the gap-free run, out_valid only after 2 accepted samples, out_valid=0 while clken=0.
REQ-035 dec_ratio=4, reset_n low for one edge after 2 accepted samples -> all outputs 0; next out_valid only after 4 further samples.
REQ-036 dec_ratio changed 4->2 after the 1st sample of a frame -> that frame dumps after 4 samples, subsequent frames after 2.

Source files
------------

// File: rtl/ddc_mixer_dec.sv
// Digital down-converter: complex mix of a real ADC stream with an NCO, then integrate-and-dump decimation.
// Three-stage pipeline (multiply, round, accumulate/dump); clken=0 freezes every data register.
module ddc_mixer_dec #(
  parameter int DIN_W  = 14,
  parameter int NCO_W  = 14,
  parameter int DOUT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic signed [DIN_W-1:0]  adc_i,
  input  logic                     adc_valid,
  input  logic signed [NCO_W-1:0]  nco_sin,
  input  logic signed [NCO_W-1:0]  nco_cos,
  input  logic                     nco_valid,
  input  logic [7:0]               dec_ratio,
  input  logic [3:0]               dec_shift,
  output logic signed [DOUT_W-1:0] i_out,
  output logic signed [DOUT_W-1:0] q_out,
  output logic                     out_valid,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int P_W   = DIN_W + NCO_W;
  localparam int M_W   = P_W - 13;
  localparam int ACC_W = 24;
  localparam logic signed [P_W-1:0] RND = P_W'(4096);

  logic                     v1_q, v1_d, v2_q, v2_d;
  logic signed [P_W-1:0]    p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [M_W-1:0]    m_i_q, m_i_d, m_q_q, m_q_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [7:0]               cnt_q, cnt_d, ratio_q, ratio_d;
  logic signed [DOUT_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                     out_valid_q, out_valid_d, ovf_q, ovf_d;

  logic signed [P_W-1:0]    adc_x, sin_x, cos_x;
  logic signed [ACC_W-1:0]  sum_i, sum_q, sh_i, sh_q;
  logic signed [DOUT_W-1:0] sat_i, sat_q;
  logic [7:0]               ratio_eff;
  logic                     dump, clamp_i, clamp_q, ovf_set;

  // Returns {clamped, value}; in range iff all bits above the output sign bit agree.
  function automatic logic [DOUT_W:0] sat(input logic signed [ACC_W-1:0] x);
    logic [ACC_W-DOUT_W:0] hi;
    hi = x[ACC_W-1:DOUT_W-1];
    if (&hi || ~|hi) sat = {1'b0, x[DOUT_W-1:0]};
    else             sat = {1'b1, x[ACC_W-1], {(DOUT_W-1){~x[ACC_W-1]}}};
  endfunction

  assign adc_x = P_W'(adc_i);
  assign sin_x = P_W'(nco_sin);
  assign cos_x = P_W'(nco_cos);

  assign sum_i = acc_i_q + ACC_W'(m_i_q);
  assign sum_q = acc_q_q + ACC_W'(m_q_q);
  assign sh_i  = sum_i >>> dec_shift;
  assign sh_q  = sum_q >>> dec_shift;
  assign {clamp_i, sat_i} = sat(sh_i);
  assign {clamp_q, sat_q} = sat(sh_q);

  assign ratio_eff = (dec_ratio == 8'd0) ? 8'd1 : dec_ratio;
  // cnt_q stays below ratio_q, so the increment never wraps.
  assign dump = v2_q && ((cnt_q + 8'd1) == ratio_q);

  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    p_i_d       = p_i_q;
    p_q_d       = p_q_q;
    m_i_d       = m_i_q;
    m_q_d       = m_q_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = 1'b0;
    ovf_set     = 1'b0;
    if (clken) begin
      v1_d = adc_valid & nco_valid;
      if (adc_valid && nco_valid) begin
        p_i_d = adc_x * cos_x;
        p_q_d = -(adc_x * sin_x);
      end
      v2_d  = v1_q;
      m_i_d = M_W'((p_i_q + RND) >>> 13);
      m_q_d = M_W'((p_q_q + RND) >>> 13);
      if (v2_q) begin
        if (dump) begin
          i_out_d     = sat_i;
          q_out_d     = sat_q;
          out_valid_d = 1'b1;
          ovf_set     = clamp_i | clamp_q;
          acc_i_d     = '0;
          acc_q_d     = '0;
          cnt_d       = 8'd0;
          ratio_d     = ratio_eff;
        end else begin
          acc_i_d = sum_i;
          acc_q_d = sum_q;
          cnt_d   = cnt_q + 8'd1;
        end
      end
    end
    // A set on the same edge as a clear wins.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      m_i_q       <= '0;
      m_q_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= 8'd0;
      ratio_q     <= ratio_eff;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      p_i_q       <= p_i_d;
      p_q_q       <= p_q_d;
      m_i_q       <= m_i_d;
      m_q_q       <= m_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
endmodule
